npc_predict_unit: RTL and testbench

//  Fetch-side next-PC generator with a direct-mapped branch target buffer (BTB) and

---
 rtl/npc_predict_unit_pkg.sv | 37 +++
 rtl/npc_predict_unit_btb.sv | 75 +++++++
 rtl/npc_predict_unit.sv | 163 ++++++++++++++++
 tb/tb_npc_predict_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/npc_predict_unit_pkg.sv
// Shared encodings for the fetch next-PC predictor.
// NPC op codes match the EX control encoding; BTB types tag stored entries.
package npc_predict_unit_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  localparam logic [1:0] BTB_TYPE_BR   = 2'b00;
  localparam logic [1:0] BTB_TYPE_JAL  = 2'b01;
  localparam logic [1:0] BTB_TYPE_JALR = 2'b10;

  function automatic logic [1:0] btb_type_of(
    input logic [1:0] npcop
  );
    logic [1:0] t;
    t = BTB_TYPE_BR;
    unique case (npcop)
      NPC_JUMP: t = BTB_TYPE_JAL;
      NPC_JALR: t = BTB_TYPE_JALR;
      default:  t = BTB_TYPE_BR;
    endcase
    return t;
  endfunction

  // Unconditional jumps always follow the target once they are in the BTB.
  function automatic logic pred_taken(
    input logic [1:0] typ,
    input logic       ctr_msb
  );
    return (typ == BTB_TYPE_JAL) |
           (typ == BTB_TYPE_JALR) |
           ctr_msb;
  endfunction

endpackage

// File: rtl/npc_predict_unit_btb.sv
// Direct-mapped BTB storage: valid/tag/target/type/counter arrays.
// Comb lookup port for IF, comb probe port for EX, one sync write port.
module npc_predict_unit_btb
  import npc_predict_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int IDX      = $clog2(ENTRIES),
  parameter int TAGW     = XLEN - IDX - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX-1:0]      rd_idx,
  output logic                rd_valid,
  output logic [TAGW-1:0]     rd_tag,
  output logic [XLEN-1:0]     rd_target,
  output logic [1:0]          rd_type,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic [IDX-1:0]      pr_idx,
  output logic                pr_valid,
  output logic [TAGW-1:0]     pr_tag,
  output logic [CTR_BITS-1:0] pr_ctr,
  input  logic                wr_en,
  input  logic [IDX-1:0]      wr_idx,
  input  logic [TAGW-1:0]     wr_tag,
  input  logic                wr_tgt_en,
  input  logic [XLEN-1:0]     wr_target,
  input  logic [1:0]          wr_type,
  input  logic [CTR_BITS-1:0] wr_ctr
);

  localparam logic [CTR_BITS-1:0] CTR_WNT =
    CTR_BITS'(1) << (CTR_BITS - 2);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          type_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_type   = type_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  assign pr_valid  = valid_q[pr_idx];
  assign pr_tag    = tag_q[pr_idx];
  assign pr_ctr    = ctr_q[pr_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

  // Payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      if (wr_tgt_en) begin
        target_q[wr_idx] <= wr_target;
        type_q[wr_idx]   <= wr_type;
      end
    end
  end

endmodule

// File: rtl/npc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction.
// EX resolves branch/jal/jalr, redirects fetch and trains the BTB.
module npc_predict_unit
  import npc_predict_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_BITS    = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pred_npc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [1:0]      ex_npcop,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu_c,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_pred_npc,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
  localparam logic [CTR_BITS-1:0] CTR_WT  =
    CTR_BITS'(1) << (CTR_BITS - 1);

  logic                rd_valid;
  logic [TAGW-1:0]     rd_tag;
  logic [XLEN-1:0]     rd_target;
  logic [1:0]          rd_type;
  logic [CTR_BITS-1:0] rd_ctr;
  logic                pr_valid;
  logic [TAGW-1:0]     pr_tag;
  logic [CTR_BITS-1:0] pr_ctr;

  logic                wr_en;
  logic                wr_tgt_en;
  logic [CTR_BITS-1:0] wr_ctr;

  logic            if_hit;
  logic            ex_hit;
  logic            taken;
  logic [XLEN-1:0] ex_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] jal_off;
  logic            is_br;
  logic            is_jal;
  logic            is_jalr;

  logic unused_bits;
  assign unused_bits = ^{ex_imm[1:0], ex_imm[XLEN-1:21],
                         ex_alu_c[1:0]};

  npc_predict_unit_btb #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[IDX+1:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_type   (rd_type),
    .rd_ctr    (rd_ctr),
    .pr_idx    (ex_pc[IDX+1:2]),
    .pr_valid  (pr_valid),
    .pr_tag    (pr_tag),
    .pr_ctr    (pr_ctr),
    .wr_en     (wr_en),
    .wr_idx    (ex_pc[IDX+1:2]),
    .wr_tag    (ex_pc[XLEN-1:IDX+2]),
    .wr_tgt_en (wr_tgt_en),
    .wr_target (redirect_pc),
    .wr_type   (btb_type_of(ex_npcop)),
    .wr_ctr    (wr_ctr)
  );

  assign if_hit = rd_valid & (rd_tag == if_pc[XLEN-1:IDX+2]);

  assign if_pred_npc =
    (if_hit & pred_taken(rd_type, rd_ctr[CTR_BITS-1]))
      ? rd_target : if_pc + XLEN'(4);

  assign is_br   = (ex_npcop == NPC_BRANCH);
  assign is_jal  = (ex_npcop == NPC_JUMP);
  assign is_jalr = (ex_npcop == NPC_JALR);

  assign ex_plus4 = ex_pc + XLEN'(4);
  assign br_off   = {{(XLEN-13){ex_imm[12]}},
                     ex_imm[12:2], 2'b00};
  assign jal_off  = {{(XLEN-21){ex_imm[20]}},
                     ex_imm[20:2], 2'b00};

  always_comb begin
    redirect_pc = ex_plus4;
    taken       = 1'b0;
    unique case (1'b1)
      is_br: begin
        taken       = ex_branch;
        redirect_pc = ex_branch ? ex_pc + br_off : ex_plus4;
      end
      is_jal: begin
        taken       = 1'b1;
        redirect_pc = ex_pc + jal_off;
      end
      is_jalr: begin
        taken       = 1'b1;
        redirect_pc = {ex_alu_c[XLEN-1:2], 2'b00};
      end
      default: begin
        taken       = 1'b0;
        redirect_pc = ex_plus4;
      end
    endcase
  end

  assign flush = !rst & ex_valid & (redirect_pc != ex_pred_npc);

  assign ex_hit = pr_valid & (pr_tag == ex_pc[XLEN-1:IDX+2]);

  // Hits always train the counter; misses allocate only when taken.
  always_comb begin
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = pr_ctr;
    if (ex_valid && !rst && ex_npcop != NPC_PLUS4) begin
      if (ex_hit) begin
        wr_en     = 1'b1;
        wr_tgt_en = taken;
        if (taken) begin
          wr_ctr = (pr_ctr == CTR_MAX) ? pr_ctr : pr_ctr + 1'b1;
        end else begin
          wr_ctr = (pr_ctr == CTR_MIN) ? pr_ctr : pr_ctr - 1'b1;
        end
      end else if (taken) begin
        wr_en     = 1'b1;
        wr_tgt_en = 1'b1;
        wr_ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc <= RESET_PC;
    end else if (flush) begin
      if_pc <= redirect_pc;
    end else if (!stall) begin
      if_pc <= if_pred_npc;
    end
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Directed bench for npc_predict_unit (4-entry BTB to force aliasing).
// EX inputs are driven directly; expected values are hand-computed.
module tb_npc_predict_unit;
  import npc_predict_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] if_pred_npc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_npcop;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_c;
  logic        ex_branch;
  logic [31:0] ex_pred_npc;
  logic        flush;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_predict_unit #(
    .BTB_ENTRIES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .if_pc       (if_pc),
    .if_pred_npc (if_pred_npc),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_npcop    (ex_npcop),
    .ex_imm      (ex_imm),
    .ex_alu_c    (ex_alu_c),
    .ex_branch   (ex_branch),
    .ex_pred_npc (ex_pred_npc),
    .flush       (flush),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc,
                    input logic [1:0] op, input logic [31:0] imm,
                    input logic [31:0] alu, input logic br,
                    input logic [31:0] pred);
    ex_valid    = v;
    ex_pc       = pc;
    ex_npcop    = op;
    ex_imm      = imm;
    ex_alu_c    = alu;
    ex_branch   = br;
    ex_pred_npc = pred;
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    #1;
  endtask

  // Steer fetch to pc with a plus4 redirect; never touches the BTB.
  task automatic goto(input logic [31:0] pc);
    ex(1'b1, pc - 32'd4, NPC_PLUS4, 32'd0, 32'd0, 1'b0, ~pc);
    step();
    idle();
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    ex(1'b1, 32'h10, NPC_JUMP, 32'h40, 32'd0, 1'b0, 32'h0);
    repeat (2) step();
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    idle();
    rst = 1'b0;
    #1;
    chk("pred_0", if_pred_npc, 32'h4);
    step();
    chk("run_4", if_pc, 32'h4);
    step();
    chk("run_8", if_pc, 32'h8);
    step();
    chk("run_c", if_pc, 32'hC);

    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h14);
    chk("cold_br_flush", {31'd0, flush}, 32'd1);
    chk("cold_br_redir", redirect_pc, 32'h30);
    step();
    chk("cold_br_pc", if_pc, 32'h30);
    goto(32'h10);
    chk("hot_br_pred", if_pred_npc, 32'h30);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h30);
    chk("hot_br_noflush", {31'd0, flush}, 32'd0);
    idle();
    step();
    chk("hot_br_follow", if_pc, 32'h30);

    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b0, 32'h30);
    chk("nt1_flush", {31'd0, flush}, 32'd1);
    chk("nt1_redir", redirect_pc, 32'h14);
    step();
    chk("nt1_pc", if_pc, 32'h14);
    goto(32'h10);
    chk("nt2_pred", if_pred_npc, 32'h14);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b0, 32'h14);
    chk("nt2_noflush", {31'd0, flush}, 32'd0);
    step();
    chk("nt2_pc", if_pc, 32'h14);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b0, 32'h14);
    step();
    goto(32'h10);
    chk("sat_low_pred", if_pred_npc, 32'h14);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h14);
    chk("tk1_flush", {31'd0, flush}, 32'd1);
    step();
    goto(32'h10);
    chk("ctr01_pred", if_pred_npc, 32'h14);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h14);
    step();
    goto(32'h10);
    chk("ctr10_pred", if_pred_npc, 32'h30);

    ex(1'b1, 32'h40, NPC_JALR, 32'd0, 32'h123, 1'b0, 32'h44);
    chk("jalr_flush", {31'd0, flush}, 32'd1);
    chk("jalr_redir", redirect_pc, 32'h120);
    step();
    chk("jalr_pc", if_pc, 32'h120);
    goto(32'h40);
    chk("jalr_pred", if_pred_npc, 32'h120);
    ex(1'b1, 32'h40, NPC_JALR, 32'd0, 32'h200, 1'b0, 32'h120);
    chk("jalr2_flush", {31'd0, flush}, 32'd1);
    chk("jalr2_redir", redirect_pc, 32'h200);
    step();
    chk("jalr2_pc", if_pc, 32'h200);
    goto(32'h40);
    chk("jalr2_pred", if_pred_npc, 32'h200);

    stall = 1'b1;
    step();
    chk("stall_hold", if_pc, 32'h40);
    ex(1'b1, 32'h80, NPC_JUMP, 32'h100, 32'd0, 1'b0, 32'h84);
    chk("stall_jal_flush", {31'd0, flush}, 32'd1);
    step();
    chk("stall_flush_pc", if_pc, 32'h180);
    stall = 1'b0;
    idle();

    ex(1'b0, 32'h100, NPC_JUMP, 32'h001FFFF0, 32'd0, 1'b0, 32'h0);
    chk("jal_neg_redir", redirect_pc, 32'hF0);
    chk("novalid_noflush", {31'd0, flush}, 32'd0);
    ex(1'b0, 32'h100, NPC_BRANCH, 32'hFFFFFFF8, 32'd0, 1'b1, 32'h0);
    chk("br_neg_redir", redirect_pc, 32'hF8);
    ex(1'b0, 32'h100, NPC_BRANCH, 32'hFFFFFFF8, 32'd0, 1'b0, 32'h0);
    chk("br_nt_redir", redirect_pc, 32'h104);
    ex(1'b0, 32'hFFFFFFFC, NPC_PLUS4, 32'd0, 32'd0, 1'b0, 32'h0);
    chk("plus4_wrap", redirect_pc, 32'h0);

    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h14);
    step();
    ex(1'b1, 32'h50, NPC_BRANCH, 32'h40, 32'd0, 1'b1, 32'h54);
    chk("alias_flush", {31'd0, flush}, 32'd1);
    chk("alias_redir", redirect_pc, 32'h90);
    step();
    goto(32'h50);
    chk("alias_new_pred", if_pred_npc, 32'h90);
    goto(32'h10);
    chk("alias_old_pred", if_pred_npc, 32'h14);
    ex(1'b1, 32'h10, NPC_BRANCH, 32'h20, 32'd0, 1'b1, 32'h14);
    chk("alias_old_flush", {31'd0, flush}, 32'd1);
    step();
    goto(32'h10);
    chk("realloc_pred", if_pred_npc, 32'h30);

    rst = 1'b1;
    step();
    chk("midrst_pc", if_pc, 32'h0);
    rst = 1'b0;
    goto(32'h10);
    chk("midrst_pred", if_pred_npc, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
